// File: rtl/countdown_timer32_pkg.sv
// Shared state encoding and default widths for the countdown timer slice.
// No logic here; imported by the prescaler and the timer top.
package countdown_timer32_pkg;

  localparam int CT_WIDTH      = 32;
  localparam int CT_PRESCALE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer32_prescaler_tick.sv
// Prescaler: tick is combinational from the registered count, high when count==prescale while enabled.
// Count holds when en=0, clr zeroes it; a count above a freshly lowered prescale wraps at 2^PRESCALE_W.
module prescaler_tick
  import countdown_timer32_pkg::*;
#(
  parameter int PRESCALE_W = CT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = en && (count == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == prescale) begin
        count <= '0;
      end else begin
        count <= count + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer32.sv
// Loadable down-counting timer with prescaled ticks, one-cycle done pulse and optional auto-reload.
// done lands N*(P+1) cycles after the RUN-entry edge; all outputs registered, no backpressure.
module countdown_timer32
  import countdown_timer32_pkg::*;
#(
  parameter int WIDTH      = CT_WIDTH,
  parameter int PRESCALE_W = CT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      q,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt, q_nxt;
  logic             done_nxt;
  logic             pre_en, pre_clr, tick;

  // A stop or load edge consumes no tick, so the prescaler is held (stop) or cleared (load).
  assign pre_en  = (state == ST_RUN) && !stop && !load;
  assign pre_clr = load;

  prescaler_tick #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (pre_en),
    .clr     (pre_clr),
    .prescale(prescale),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      q          <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      reload_reg <= reload_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload_reg;
    done_nxt   = 1'b0;

    if (load) begin
      q_nxt      = load_val;
      reload_nxt = load_val;
      if (state == ST_EXPIRED) begin
        state_nxt = ST_IDLE;
      end
    end

    if (stop) begin
      if (state == ST_RUN) begin
        state_nxt = ST_PAUSE;
      end
    end else if (start) begin
      // Leaving EXPIRED needs a non-zero count, which only a same-edge load can supply.
      if ((state == ST_IDLE) || (state == ST_PAUSE)) begin
        state_nxt = ST_RUN;
      end else if ((state == ST_EXPIRED) && (q_nxt != '0)) begin
        state_nxt = ST_RUN;
      end
    end

    if (tick) begin
      if (q > WIDTH'(1)) begin
        q_nxt = q - WIDTH'(1);
      end else if ((q == WIDTH'(1)) && auto_reload && (reload_reg != '0)) begin
        q_nxt    = reload_reg;
        done_nxt = 1'b1;
      end else begin
        q_nxt     = '0;
        done_nxt  = 1'b1;
        state_nxt = ST_EXPIRED;
      end
    end
  end

  assign running = (state == ST_RUN);
  assign expired = (state == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer32.sv
// Directed bench for countdown_timer32: reset, one-shot, prescale, auto-reload, pause and zero-load cases.
module tb_countdown_timer32;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] load_val;
  logic        start;
  logic        stop;
  logic        auto_reload;
  logic [15:0] prescale;
  logic [31:0] q;
  logic        running;
  logic        done;
  logic        expired;

  int n_total = 0;
  int n_pass  = 0;

  countdown_timer32 dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .prescale   (prescale),
    .q          (q),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [31:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int pulses;
  logic saw_zero;

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = '0;
    #12;
    check("rst_q", q, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_expired", expired, 0);
    step();
    rst = 1'b0;

    // Reset mid-run aborts without a done pulse
    load = 1'b1; load_val = 100; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    check("midrst_run", running, 1);
    check("midrst_q100", q, 100);
    for (int i = 0; i < 10; i++) step();
    check("midrst_q90", q, 90);
    rst = 1'b1;
    #2;
    check("midrst_q", q, 0);
    check("midrst_running", running, 0);
    check("midrst_done", done, 0);
    step();
    step();
    check("midrst_done_hold", done, 0);
    rst = 1'b0;

    // One-shot, prescale 0
    pulse_load(5);
    check("os_load_q", q, 5);
    check("os_load_idle", running, 0);
    pulse_start();
    check("os_entry_q", q, 5);
    check("os_entry_run", running, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("os_q_%0d", k), q, 32'(5 - k));
      check($sformatf("os_done_%0d", k), done, (k == 5) ? 1 : 0);
      check($sformatf("os_exp_%0d", k), expired, (k == 5) ? 1 : 0);
    end
    step();
    check("os_done_clear", done, 0);
    check("os_expired_hold", expired, 1);
    check("os_q_hold", q, 0);

    // Start in EXPIRED with q=0 is ignored
    pulse_start();
    check("exp_start_ign", expired, 1);
    check("exp_start_norun", running, 0);

    // Load in EXPIRED returns to IDLE, then prescaled run: 3 ticks of 4 cycles
    prescale = 3;
    pulse_load(3);
    check("exp_load_exp", expired, 0);
    check("exp_load_run", running, 0);
    check("exp_load_q", q, 3);
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("ps_q_%0d", c), q, 32'(3 - c / 4));
      check($sformatf("ps_done_%0d", c), done, (c == 12) ? 1 : 0);
    end
    check("ps_expired", expired, 1);

    // Auto-reload: period of 4 ticks, q never 0
    prescale = 0;
    auto_reload = 1'b1;
    pulse_load(4);
    pulse_start();
    pulses = 0;
    saw_zero = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      check($sformatf("ar_q_%0d", c), q, (c % 4 == 0) ? 4 : 32'(4 - c % 4));
      if (done) pulses++;
      if (q == 0) saw_zero = 1'b1;
    end
    check("ar_pulses", 32'(pulses), 5);
    check("ar_no_zero", {31'd0, saw_zero}, 0);
    check("ar_running", running, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    auto_reload = 1'b0;
    check("ar_paused", running, 0);

    // Pause/resume and stop-over-start priority
    pulse_load(10);
    check("pr_load_paused", running, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) step();
    check("pr_q7", q, 7);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("pr_stopped", running, 0);
    for (int i = 0; i < 20; i++) step();
    check("pr_q7_held", q, 7);
    check("pr_no_done", done, 0);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("pr_stop_wins", running, 0);
    check("pr_stop_wins_q", q, 7);
    pulse_start();
    check("pr_resumed", running, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("pr_q_%0d", k), q, 32'(7 - k));
      check($sformatf("pr_done_%0d", k), done, (k == 7) ? 1 : 0);
    end
    check("pr_expired", expired, 1);

    // Start with q=0: done on first tick, no underflow
    pulse_load(0);
    check("z_idle", expired, 0);
    pulse_start();
    check("z_run", running, 1);
    step();
    check("z_done", done, 1);
    check("z_expired", expired, 1);
    check("z_q", q, 0);
    step();
    check("z_done_clear", done, 0);
    check("z_q_hold", q, 0);

    // Load while running takes effect next edge, stays in RUN
    pulse_load(30);
    pulse_start();
    for (int i = 0; i < 10; i++) step();
    check("lr_q20", q, 20);
    pulse_load(50);
    check("lr_q50", q, 50);
    check("lr_running", running, 1);
    step();
    check("lr_q49", q, 49);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/countdown_timer32.md
Name: countdown_timer32

Overview:
- Loadable 32-bit down-counting timer; the decrementing counterpart to the team's free-running up-counter.
- Counts a programmed value down to zero at a prescaled tick rate.
- Emits a one-cycle done pulse at terminal count; optionally auto-reloads for periodic events.
- Sits beside the display/clock-divider logic as the event and timeout source for the top level.

Parameters:
WIDTH, 32, counter and load-value width
PRESCALE_W, 16, prescaler divisor width

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
load  input  1  capture load_val into q and reload register
load_val  input  WIDTH  value to load
start  input  1  begin or resume counting
stop  input  1  pause counting
auto_reload  input  1  1 = reload at terminal count, 0 = one-shot
prescale  input  PRESCALE_W  tick every prescale+1 clk cycles
q  output  WIDTH  current count
running  output  1  high in RUN state
done  output  1  one-cycle pulse at terminal count
expired  output  1  high in EXPIRED state

Behaviour:
- Reset (async, rst=1):
  - q=0, reload_reg=0, prescaler count=0, done=0, state=IDLE.
  - Hence running=0, expired=0.
  - Reset asserted mid-count aborts immediately; no done pulse.
- All other updates occur on posedge clk. Outputs are registered.
- States:
  - IDLE: not counting.
  - RUN: counting.
  - PAUSE: counting suspended, q held.
  - EXPIRED: one-shot finished, q=0.
- Priority within a cycle: load, then stop, then start.
- load (any state):
  - q<=load_val, reload_reg<=load_val, prescaler cleared.
  - State unchanged, except EXPIRED -> IDLE.
  - load together with start in IDLE/PAUSE: load applies and the state goes to RUN in the same edge.
- stop: RUN -> PAUSE. Prescaler count held, not cleared. stop together with start: stop wins.
- start:
  - IDLE/PAUSE -> RUN.
  - EXPIRED -> RUN only if q != 0 after a load; otherwise ignored.
  - start in RUN is ignored.
- Prescaler:
  - Runs only in RUN.
  - tick=1 when count==prescale; count then wraps to 0.
  - prescale=0: tick every cycle.
  - prescale changed mid-run: takes effect on the next compare. If count>prescale, the count wraps at 2^PRESCALE_W (no early tick).
- On tick in RUN:
  - q>1: q<=q-1.
  - q==1 with auto_reload=1 and reload_reg!=0: q<=reload_reg, done<=1, stay in RUN. The period is exactly reload_reg ticks.
  - q==1 otherwise: q<=0, done<=1, RUN -> EXPIRED.
  - q==0 (entered RUN with zero): done<=1 on the first tick, -> EXPIRED, no underflow.
- done is high for exactly one clk cycle per terminal event and is 0 in every other cycle.
- Arithmetic: unsigned, no wrap below 0. q never passes through 2^WIDTH-1.
- Latency: with load_val=N and prescale=P, done is asserted N*(P+1) cycles after the RUN-entry edge.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_EXPIRED=2'd3), WIDTH and PRESCALE_W defaults.
- Sub-module prescaler_tick:
  - Inputs: clk, rst, en, clr, prescale.
  - Output: tick.
  - Holds count when en=0; clr zeroes count.
- Top module contains the FSM, the q/reload_reg datapath and the done register.

Test Plan:
- Reset mid-run: load 100, start, assert rst after 10 cycles -> q=0, state IDLE, running=0, no done pulse.
- One-shot timing: load 5, prescale=0, start -> q steps 5,4,3,2,1,0 one per cycle; done high one cycle when q=0 first appears; expired=1 thereafter.
- Prescaled count: load 3, prescale=3, start -> done asserted 12 cycles after the RUN edge; q decrements every 4 cycles.
- Auto-reload: load 4, auto_reload=1, prescale=0, run 20 cycles -> done pulses every 4 cycles (5 pulses); q cycles 4,3,2,1,4 and never reaches 0.
- Pause/resume and priority:
  - load 10, start, stop after 3 ticks -> q=7 held for 20 cycles.
  - start -> resumes; done after 7 more ticks.
  - stop and start asserted together -> stays paused.
- Zero and load-while-running:
  - start with q=0 -> done on the first tick, EXPIRED.
  - load 50 during RUN at q=20 -> q=50 next edge, still RUN.
  - load in EXPIRED -> IDLE.
